dcache_direct_wb: RTL

- Direct-mapped, write-back, write-allocate data cache between the pipeline's D-cache port (word-addressed, 32-bit) and main memory (128-bit block interface).
- Directly downstream of the MEM stage. It consumes the DCACHE_ren/wen/addr/wdata it produces and returns rdata and a stall signal.
- Hits complete in the request cycle with no stall. Misses stall the pipeline through an optional dirty write-back followed by a block fill.

---
 rtl/dcache_pkg.sv | 32 +++
 rtl/dcache_line_array.sv | 56 +++++
 rtl/dcache_direct_wb.sv | 120 ++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped write-back data cache.
package dcache_pkg;

    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned OFS_W   = 2;
    localparam int unsigned WORD_W  = 32;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StWriteback = 2'd1,
        StAllocate  = 2'd2
    } state_e;

    // Fields are full-width; callers keep only the low TAG_W / IDX_W bits.
    typedef struct packed {
        logic [31:0]      tag;
        logic [31:0]      idx;
        logic [OFS_W-1:0] ofs;
    } addr_split_t;

    function automatic addr_split_t split_addr(input logic [31:0] addr,
                                               input int unsigned idx_w);
        addr_split_t s;
        logic [31:0] mask;
        mask  = (32'd1 << idx_w) - 32'd1;
        s.ofs = addr[OFS_W-1:0];
        s.idx = (addr >> OFS_W) & mask;
        s.tag = addr >> (OFS_W + idx_w);
        return s;
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Tag/valid/dirty/data storage: combinational read, word write (sets dirty), block fill (clears it).
module dcache_line_array
    import dcache_pkg::*;
#(
    parameter int unsigned NUM_BLOCKS = 8,
    parameter int unsigned IDX_W      = 3,
    parameter int unsigned TAG_W      = 25
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IDX_W-1:0]   idx_i,
    output logic [TAG_W-1:0]   tag_o,
    output logic               valid_o,
    output logic               dirty_o,
    output logic [BLOCK_W-1:0] data_o,
    input  logic               word_we_i,
    input  logic [OFS_W-1:0]   word_ofs_i,
    input  logic [WORD_W-1:0]  word_i,
    input  logic               fill_we_i,
    input  logic [TAG_W-1:0]   fill_tag_i,
    input  logic [BLOCK_W-1:0] fill_data_i
);

    logic [TAG_W-1:0]   tag_q   [NUM_BLOCKS];
    logic [BLOCK_W-1:0] data_q  [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] valid_q;
    logic [NUM_BLOCKS-1:0] dirty_q;

    assign tag_o   = tag_q[idx_i];
    assign data_o  = data_q[idx_i];
    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_we_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (word_we_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

    // Tag and data are deliberately left out of reset; valid gates their use.
    always_ff @(posedge clk) begin
        if (fill_we_i) begin
            tag_q[idx_i]  <= fill_tag_i;
            data_q[idx_i] <= fill_data_i;
        end else if (word_we_i) begin
            data_q[idx_i][32'(word_ofs_i) * WORD_W +: WORD_W] <= word_i;
        end
    end

endmodule

// File: rtl/dcache_direct_wb.sv
// Direct-mapped, write-back, write-allocate D-cache: hits in the request cycle, misses stall.
module dcache_direct_wb
    import dcache_pkg::*;
#(
    parameter int unsigned NUM_BLOCKS = 8,
    parameter int unsigned ADDR_W     = 30,
    localparam int unsigned IDX_W     = $clog2(NUM_BLOCKS),
    localparam int unsigned TAG_W     = ADDR_W - IDX_W - OFS_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     proc_read_i,
    input  logic                     proc_write_i,
    input  logic [ADDR_W-1:0]        proc_addr_i,
    input  logic [WORD_W-1:0]        proc_wdata_i,
    output logic [WORD_W-1:0]        proc_rdata_o,
    output logic                     proc_stall_o,
    output logic                     mem_read_o,
    output logic                     mem_write_o,
    output logic [TAG_W+IDX_W-1:0]   mem_addr_o,
    output logic [BLOCK_W-1:0]       mem_wdata_o,
    input  logic [BLOCK_W-1:0]       mem_rdata_i,
    input  logic                     mem_ready_i
);

    state_e state_q, state_d;

    addr_split_t        split;
    logic [TAG_W-1:0]   addr_tag;
    logic [IDX_W-1:0]   addr_idx;
    logic [OFS_W-1:0]   addr_ofs;
    logic               unused_split;

    assign split        = split_addr(32'(proc_addr_i), IDX_W);
    assign addr_tag     = split.tag[TAG_W-1:0];
    assign addr_idx     = split.idx[IDX_W-1:0];
    assign addr_ofs     = split.ofs;
    assign unused_split = ^{split.tag[31:TAG_W], split.idx[31:IDX_W]};

    logic [TAG_W-1:0]   line_tag;
    logic               line_valid;
    logic               line_dirty;
    logic [BLOCK_W-1:0] line_data;
    logic               word_we;
    logic               fill_we;
    logic               hit;
    logic               req;

    dcache_line_array #(
        .NUM_BLOCKS (NUM_BLOCKS),
        .IDX_W      (IDX_W),
        .TAG_W      (TAG_W)
    ) u_lines (
        .clk         (clk),
        .rst_n       (rst_n),
        .idx_i       (addr_idx),
        .tag_o       (line_tag),
        .valid_o     (line_valid),
        .dirty_o     (line_dirty),
        .data_o      (line_data),
        .word_we_i   (word_we),
        .word_ofs_i  (addr_ofs),
        .word_i      (proc_wdata_i),
        .fill_we_i   (fill_we),
        .fill_tag_i  (addr_tag),
        .fill_data_i (mem_rdata_i)
    );

    assign hit = line_valid && (line_tag == addr_tag);
    assign req = proc_read_i || proc_write_i;

    always_comb begin
        state_d      = state_q;
        proc_stall_o = 1'b0;
        proc_rdata_o = '0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        word_we      = 1'b0;
        fill_we      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req && hit) begin
                    // A simultaneous read and write is treated as the write.
                    word_we = proc_write_i;
                    if (proc_read_i) begin
                        proc_rdata_o = line_data[32'(addr_ofs) * WORD_W +: WORD_W];
                    end
                end else if (req) begin
                    proc_stall_o = 1'b1;
                    state_d      = (line_valid && line_dirty) ? StWriteback : StAllocate;
                end
            end
            StWriteback: begin
                proc_stall_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {line_tag, addr_idx};
                mem_wdata_o  = line_data;
                if (mem_ready_i) state_d = StAllocate;
            end
            StAllocate: begin
                proc_stall_o = 1'b1;
                mem_read_o   = 1'b1;
                mem_addr_o   = {addr_tag, addr_idx};
                if (mem_ready_i) begin
                    fill_we = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

endmodule
